// File: rtl/compmul_pipe.sv
// compmul_pipe: pipelined complex multiplier, res = a*b or a*conj(b) per sample.
//
// Uses the 3-multiplier (Gauss) decomposition over three register stages:
//   S1: operands, tag and pre-adds (b_im is conjugated here when requested)
//   S2: the three products
//   S3: recombine, round, shift, saturate (output register)
// Latency is 3 cycles, throughput 1 sample/cycle. One global enable stalls
// every stage together; bubbles are carried, not collapsed.
//
// Build option: define COMPMUL_PIPE_ROUND_EN for round-half-up before the
// fractional shift; otherwise the result is truncated (floor).
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     input handshake (o_ready is combinational from i_ready)
//   i_a_re, i_a_im        operand a, Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH
//   i_b_re, i_b_im        operand b
//   i_conj                1: multiply by conj(b)
//   i_tag                 sideband carried with the sample
//   o_valid / i_ready     output handshake
//   o_res_re, o_res_im    saturated result
//   o_tag                 tag aligned with the result
//   o_ovf                 result saturated in re or im
module compmul_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 12,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_a_re,
   input  logic [DATA_WIDTH-1:0] i_a_im,
   input  logic [DATA_WIDTH-1:0] i_b_re,
   input  logic [DATA_WIDTH-1:0] i_b_im,
   input  logic                  i_conj,
   input  logic [TAG_WIDTH-1:0]  i_tag,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_res_re,
   output logic [DATA_WIDTH-1:0] o_res_im,
   output logic [TAG_WIDTH-1:0]  o_tag,
   output logic                  o_ovf
);

   localparam int W  = DATA_WIDTH;
   localparam int PW = 2 * W + 2;  // product width
   localparam int SW = 2 * W + 3;  // recombined sum width

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};

`ifdef COMPMUL_PIPE_ROUND_EN
   localparam logic signed [SW-1:0] RND = {{(SW - FRAC_WIDTH){1'b0}}, 1'b1,
                                           {(FRAC_WIDTH - 1){1'b0}}};
`else
   localparam logic signed [SW-1:0] RND = '0;
`endif

   // Returns {ovf, clamped value}
   function automatic logic [W:0] saturate(input logic signed [SW-1:0] v);
      if (v > SAT_MAX) begin
         return {1'b1, 1'b0, {(W - 1){1'b1}}};
      end else if (v < SAT_MIN) begin
         return {1'b1, 1'b1, {(W - 1){1'b0}}};
      end else begin
         return {1'b0, v[W-1:0]};
      end
   endfunction

   // ---------------------------------------------------------------- handshake
   logic stall;
   logic adv;

   assign stall   = o_valid & ~i_ready;
   assign adv     = ~stall;
   assign o_ready = adv;

   // ---------------------------------------------------------------- S1
   // b_im' carries one extra bit so negating the most negative value is exact.
   logic signed [W:0]   b_im_x;
   logic signed [W:0]   b_im_c;
   logic signed [W+1:0] d0_c;
   logic signed [W+1:0] d1_c;
   logic signed [W+1:0] d2_c;

   assign b_im_x = $signed({i_b_im[W-1], i_b_im});
   assign b_im_c = i_conj ? -b_im_x : b_im_x;
   assign d0_c   = $signed({{2{i_a_re[W-1]}}, i_a_re}) - $signed({{2{i_a_im[W-1]}}, i_a_im});
   assign d1_c   = $signed({{2{i_b_re[W-1]}}, i_b_re}) - $signed({b_im_c[W], b_im_c});
   assign d2_c   = $signed({{2{i_b_re[W-1]}}, i_b_re}) + $signed({b_im_c[W], b_im_c});

   logic                 s1_valid_q;
   logic [W-1:0]         s1_a_re_q;
   logic [W-1:0]         s1_a_im_q;
   logic [W-1:0]         s1_b_re_q;
   logic [W+1:0]         s1_d0_q;
   logic [W+1:0]         s1_d1_q;
   logic [W+1:0]         s1_d2_q;
   logic [TAG_WIDTH-1:0] s1_tag_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
         s1_a_re_q  <= '0;
         s1_a_im_q  <= '0;
         s1_b_re_q  <= '0;
         s1_d0_q    <= '0;
         s1_d1_q    <= '0;
         s1_d2_q    <= '0;
         s1_tag_q   <= '0;
      end else if (adv) begin
         s1_valid_q <= i_valid;
         s1_a_re_q  <= i_a_re;
         s1_a_im_q  <= i_a_im;
         s1_b_re_q  <= i_b_re;
         s1_d0_q    <= d0_c;
         s1_d1_q    <= d1_c;
         s1_d2_q    <= d2_c;
         s1_tag_q   <= i_tag;
      end
   end

   // ---------------------------------------------------------------- S2
   // p0 = b_re*d0, p1 = a_im*d1, p2 = a_re*d2; operands sign-extended to PW bits.
   logic signed [PW-1:0] p0_c;
   logic signed [PW-1:0] p1_c;
   logic signed [PW-1:0] p2_c;

   assign p0_c = $signed({{(W + 2){s1_b_re_q[W-1]}}, s1_b_re_q})
               * $signed({{W{s1_d0_q[W+1]}}, s1_d0_q});
   assign p1_c = $signed({{(W + 2){s1_a_im_q[W-1]}}, s1_a_im_q})
               * $signed({{W{s1_d1_q[W+1]}}, s1_d1_q});
   assign p2_c = $signed({{(W + 2){s1_a_re_q[W-1]}}, s1_a_re_q})
               * $signed({{W{s1_d2_q[W+1]}}, s1_d2_q});

   logic                 s2_valid_q;
   logic [PW-1:0]        s2_p0_q;
   logic [PW-1:0]        s2_p1_q;
   logic [PW-1:0]        s2_p2_q;
   logic [TAG_WIDTH-1:0] s2_tag_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_q <= 1'b0;
         s2_p0_q    <= '0;
         s2_p1_q    <= '0;
         s2_p2_q    <= '0;
         s2_tag_q   <= '0;
      end else if (adv) begin
         s2_valid_q <= s1_valid_q;
         s2_p0_q    <= p0_c;
         s2_p1_q    <= p1_c;
         s2_p2_q    <= p2_c;
         s2_tag_q   <= s1_tag_q;
      end
   end

   // ---------------------------------------------------------------- S3
   logic signed [SW-1:0] re_sum;
   logic signed [SW-1:0] im_sum;
   logic signed [SW-1:0] re_sh;
   logic signed [SW-1:0] im_sh;
   logic [W:0]           re_sat;
   logic [W:0]           im_sat;

   assign re_sum = $signed({s2_p1_q[PW-1], s2_p1_q}) + $signed({s2_p0_q[PW-1], s2_p0_q});
   assign im_sum = $signed({s2_p2_q[PW-1], s2_p2_q}) - $signed({s2_p0_q[PW-1], s2_p0_q});
   assign re_sh  = (re_sum + RND) >>> FRAC_WIDTH;
   assign im_sh  = (im_sum + RND) >>> FRAC_WIDTH;
   assign re_sat = saturate(re_sh);
   assign im_sat = saturate(im_sh);

   logic                 s3_valid_q;
   logic [W-1:0]         s3_re_q;
   logic [W-1:0]         s3_im_q;
   logic [TAG_WIDTH-1:0] s3_tag_q;
   logic                 s3_ovf_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s3_valid_q <= 1'b0;
         s3_re_q    <= '0;
         s3_im_q    <= '0;
         s3_tag_q   <= '0;
         s3_ovf_q   <= 1'b0;
      end else if (adv) begin
         s3_valid_q <= s2_valid_q;
         s3_re_q    <= re_sat[W-1:0];
         s3_im_q    <= im_sat[W-1:0];
         s3_tag_q   <= s2_tag_q;
         s3_ovf_q   <= re_sat[W] | im_sat[W];
      end
   end

   assign o_valid  = s3_valid_q;
   assign o_res_re = s3_re_q;
   assign o_res_im = s3_im_q;
   assign o_tag    = s3_tag_q;
   assign o_ovf    = s3_ovf_q;

endmodule

// File: tb/tb_compmul_pipe.sv
// Directed-vector bench for compmul_pipe with hand-computed expected results.
module tb_compmul_pipe;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_a_re, i_a_im, i_b_re, i_b_im;
   logic        i_conj;
   logic [3:0]  i_tag;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_res_re, o_res_im;
   logic [3:0]  o_tag;
   logic        o_ovf;

   int n_vec = 0;
   int n_err = 0;

   compmul_pipe #(
      .DATA_WIDTH(16),
      .FRAC_WIDTH(12),
      .TAG_WIDTH (4)
   ) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a_re  (i_a_re),
      .i_a_im  (i_a_im),
      .i_b_re  (i_b_re),
      .i_b_im  (i_b_im),
      .i_conj  (i_conj),
      .i_tag   (i_tag),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res_re(o_res_re),
      .o_res_im(o_res_im),
      .o_tag   (o_tag),
      .o_ovf   (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] ar, input logic [15:0] ai, input logic [15:0] br,
                        input logic [15:0] bi, input logic cj, input logic [3:0] tg);
      i_a_re = ar;
      i_a_im = ai;
      i_b_re = br;
      i_b_im = bi;
      i_conj = cj;
      i_tag  = tg;
   endtask

   // One isolated sample: checks acceptance, 3-cycle latency and the result.
   task automatic send_one(input string name,
                           input logic [15:0] ar, input logic [15:0] ai,
                           input logic [15:0] br, input logic [15:0] bi,
                           input logic cj, input logic [3:0] tg,
                           input logic [15:0] er, input logic [15:0] ei, input logic eo);
      int cyc;
      drive(ar, ai, br, bi, cj, tg);
      i_valid = 1'b1;
      i_ready = 1'b1;
      #1;
      check_val({name, "_ready"}, 32'(o_ready), 32'd1);
      tick();
      i_valid = 1'b0;
      cyc = 1;
      while (!o_valid && cyc < 10) begin
         tick();
         cyc++;
      end
      check_val({name, "_latency"}, 32'(cyc), 32'd3);
      check_val({name, "_re"}, 32'(o_res_re), 32'(er));
      check_val({name, "_im"}, 32'(o_res_im), 32'(ei));
      check_val({name, "_tag"}, 32'(o_tag), 32'(tg));
      check_val({name, "_ovf"}, 32'(o_ovf), 32'(eo));
      tick();
   endtask

   int          sent, rcv, extra;
   logic        prev_stall;
   logic [15:0] held_re, held_im;
   logic [3:0]  held_tag;

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      drive(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0);
      tick();
      tick();
      check_val("rst_valid", 32'(o_valid), 32'd0);
      check_val("rst_ready", 32'(o_ready), 32'd1);
      check_val("rst_re", 32'(o_res_re), 32'd0);
      check_val("rst_im", 32'(o_res_im), 32'd0);
      check_val("rst_tag", 32'(o_tag), 32'd0);
      check_val("rst_ovf", 32'(o_ovf), 32'd0);
      i_rst = 1'b0;
      tick();

      // 1.0 * j = j
      send_one("basic", 16'h1000, 16'h0000, 16'h0000, 16'h1000, 1'b0, 4'd5,
               16'h0000, 16'h1000, 1'b0);
      // j * conj(j) = 1, j * j = -1
      send_one("conj1", 16'h0000, 16'h1000, 16'h0000, 16'h1000, 1'b1, 4'd6,
               16'h1000, 16'h0000, 1'b0);
      send_one("conj0", 16'h0000, 16'h1000, 16'h0000, 16'h1000, 1'b0, 4'd7,
               16'hF000, 16'h0000, 1'b0);
      // (1.5+0.5j)(0.5-1j) = 1.25-1.25j ; with conj(b): 0.25+1.75j
      send_one("mix0", 16'h1800, 16'h0800, 16'h0800, 16'hF000, 1'b0, 4'd8,
               16'h1400, 16'hEC00, 1'b0);
      send_one("mix1", 16'h1800, 16'h0800, 16'h0800, 16'hF000, 1'b1, 4'd9,
               16'h0400, 16'h1C00, 1'b0);
      // (-8)(-8) = 64 saturates re
      send_one("sat0", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 4'd10,
               16'h7FFF, 16'h0000, 1'b1);
      // -8 * conj(-8-8j) = 64-64j, both clamp; no wrap from negating -8
      send_one("sat1", 16'h8000, 16'h0000, 16'h8000, 16'h8000, 1'b1, 4'd11,
               16'h7FFF, 16'h8000, 1'b1);
`ifdef COMPMUL_PIPE_ROUND_EN
      send_one("rnd_pos", 16'h0001, 16'h0000, 16'h0800, 16'h0000, 1'b0, 4'd12,
               16'h0001, 16'h0000, 1'b0);
      send_one("rnd_neg", 16'hFFFF, 16'h0000, 16'h0800, 16'h0000, 1'b0, 4'd13,
               16'h0000, 16'h0000, 1'b0);
`else
      send_one("rnd_pos", 16'h0001, 16'h0000, 16'h0800, 16'h0000, 1'b0, 4'd12,
               16'h0000, 16'h0000, 1'b0);
      send_one("rnd_neg", 16'hFFFF, 16'h0000, 16'h0800, 16'h0000, 1'b0, 4'd13,
               16'hFFFF, 16'h0000, 1'b0);
`endif

      // Backpressure: sample k is a=(k+1)/16, b=1+j -> res=(k+1)/16*(1+j)
      sent       = 0;
      rcv        = 0;
      prev_stall = 1'b0;
      held_re    = '0;
      held_im    = '0;
      held_tag   = '0;
      for (int c = 0; c < 60 && rcv < 8; c++) begin
         i_ready = !(c >= 6 && c < 11);
         i_valid = (sent < 8);
         drive(16'((sent + 1) << 8), 16'h0000, 16'h1000, 16'h1000, 1'b0, 4'(sent + 1));
         #1;
         if (o_valid && !i_ready) begin
            check_val("bp_ready_low", 32'(o_ready), 32'd0);
            if (prev_stall) begin
               check_val("bp_hold_re", 32'(o_res_re), 32'(held_re));
               check_val("bp_hold_im", 32'(o_res_im), 32'(held_im));
               check_val("bp_hold_tag", 32'(o_tag), 32'(held_tag));
            end
            held_re    = o_res_re;
            held_im    = o_res_im;
            held_tag   = o_tag;
            prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         if (o_valid && i_ready) begin
            check_val("bp_re", 32'(o_res_re), 32'((rcv + 1) << 8));
            check_val("bp_im", 32'(o_res_im), 32'((rcv + 1) << 8));
            check_val("bp_tag", 32'(o_tag), 32'(rcv + 1));
            rcv++;
         end
         if (i_valid && o_ready) sent++;
         tick();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      check_val("bp_count", 32'(rcv), 32'd8);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         if (o_valid) extra++;
         tick();
      end
      check_val("bp_no_dup", 32'(extra), 32'd0);

      // Reset with three saturating samples in flight
      i_ready = 1'b1;
      drive(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 4'd3);
      i_valid = 1'b1;
      tick();
      tick();
      tick();
      i_valid = 1'b0;
      check_val("pre_rst_valid", 32'(o_valid), 32'd1);
      check_val("pre_rst_ovf", 32'(o_ovf), 32'd1);
      #2;
      i_rst = 1'b1;
      #1;
      check_val("mid_rst_valid", 32'(o_valid), 32'd0);
      check_val("mid_rst_re", 32'(o_res_re), 32'd0);
      check_val("mid_rst_im", 32'(o_res_im), 32'd0);
      check_val("mid_rst_ovf", 32'(o_ovf), 32'd0);
      check_val("mid_rst_tag", 32'(o_tag), 32'd0);
      tick();
      i_rst = 1'b0;
      tick();
      tick();
      tick();
      check_val("post_rst_flushed", 32'(o_valid), 32'd0);
      send_one("post_rst", 16'h1800, 16'h0800, 16'h0800, 16'hF000, 1'b0, 4'd14,
               16'h1400, 16'hEC00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/compmul_pipe.md
Name: compmul_pipe

Overview:
- Pipelined, parametrised successor to the FFT complex multiplier.
- Computes a*b, or a*conj(b) when selected per sample. Uses the 3-multiplier (Gauss) decomposition, with registered stages and a valid/ready handshake.
- Output is rounded and saturated instead of bit-sliced.
- Sits between the twiddle ROM/data buffer and the butterfly stages of the RX/TX FFT and IFFT, and is reused for channel-equaliser multiplies.

Parameters:
DATA_WIDTH, 16, width of each real/imag input and output word (signed two's complement)
FRAC_WIDTH, 12, fractional bits of inputs and outputs (Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH)
TAG_WIDTH, 4, width of sideband tag carried alongside each sample (e.g. bin index LSBs)

Ports:
i_clk  input  1  clock; all state on rising edge
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  input sample valid
o_ready  output  1  block can accept input this cycle
i_a_re  input  DATA_WIDTH  operand a, real
i_a_im  input  DATA_WIDTH  operand a, imag
i_b_re  input  DATA_WIDTH  operand b, real
i_b_im  input  DATA_WIDTH  operand b, imag
i_conj  input  1  1: use conj(b)
i_tag  input  TAG_WIDTH  sideband, passed through with the sample
o_valid  output  1  output sample valid
i_ready  input  1  downstream accepts output
o_res_re  output  DATA_WIDTH  result, real
o_res_im  output  DATA_WIDTH  result, imag
o_tag  output  TAG_WIDTH  tag aligned with result
o_ovf  output  1  1 when this output sample was saturated (re or im)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. i_rst clears all stage valid bits and all data, tag and o_ovf registers to 0. This applies immediately, including mid-operation; in-flight samples are discarded.
- Pipeline: 3 register stages, S1, S2 and S3 (S3 = output register). Latency is exactly 3 cycles from input acceptance to o_valid when unstalled. Throughput is 1 sample/cycle.
- S1: register operands, tag and conj. Form b_im' = conj ? -b_im : b_im in DATA_WIDTH+1 bits, so -(-2^(W-1)) does not overflow. Pre-add d0 = a_re - a_im, d1 = b_re - b_im', d2 = b_re + b_im', each DATA_WIDTH+2 bits.
- S2: products p0 = b_re*d0, p1 = a_im*d1, p2 = a_re*d2, each 2*DATA_WIDTH+2 bits signed.
- S3: re = p1 + p0, im = p2 - p0 (2*DATA_WIDTH+3 bits). Apply rounding (see Optional Feature), then arithmetic right shift by FRAC_WIDTH. Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Set o_ovf if either component clamped.
- Handshake:
  - stall = o_valid & ~i_ready.
  - o_ready = ~stall; this is a combinational path from i_ready, documented for integrators.
  - Input accepted when i_valid & o_ready.
  - During stall, all stages hold; o_res_*, o_tag and o_ovf are stable.
  - Bubbles propagate and are not collapsed.
- Output transfer occurs when o_valid & i_ready. Simultaneous transfer and acceptance are allowed in the same cycle, with no lost or duplicated samples.
- i_valid low: 0 enters S1. Data registers may update but are don't-care when the valid bit is 0.
- Ordering: strictly FIFO; the tag stays attached to its sample.

Optional Feature:
- Macro COMPMUL_PIPE_ROUND_EN.
- Defined: round-half-up. Add 2^(FRAC_WIDTH-1) to re/im before the shift, then saturate.
- Undefined: truncation (floor via arithmetic shift), bit-exact with the legacy FFT multiplier for non-saturating inputs.
- Latency is identical in both builds.

Test Plan:
- Basic/latency: a=0x1000 (1.0), b=0x0000+j0x1000 (j), conj=0, tag=5, i_ready=1. Expect o_valid exactly 3 cycles after acceptance, res=0x0000+j0x1000, o_tag=5, o_ovf=0.
- Conjugate: a=j0x1000, b=j0x1000, conj=1 -> res=0x1000+j0x0000. Same operands with conj=0 -> res=0xF000 (-1.0)+j0.
- Saturation: a=b=0x8000 (-8.0)+j0, conj=0 -> res_re=0x7FFF, res_im=0, o_ovf=1. Same with conj=1 and b_im=0x8000 -> no internal wrap; result matches the golden model.
- Rounding: a=0x0001, b=0x0800. With COMPMUL_PIPE_ROUND_EN -> re=1; without -> re=0. a=0xFFFF, b=0x0800: with -> 0; without -> 0xFFFF.
- Backpressure: stream 8 distinct samples with i_valid=1; hold i_ready=0 for 5 cycles mid-stream. Expect o_ready=0 while o_valid=1, outputs stable during the stall, all 8 results in order, none lost or duplicated.
- Reset mid-stream: assert i_rst asynchronously with 3 samples in flight. Expect o_valid, o_res_* and o_ovf = 0 immediately. After release, a new sample emerges after 3 cycles with the correct value.
